dmem_responder: RTL and testbench

Data-memory responder for the pipelined RV32 core. It serves load and store requests issued from the MEM stage over a hold-until-done request/response interface, with a configurable wait-state latency. It does byte-lane alignment, misalignment and range checking, and reports faults with RISC-V mcause codes. It replaces the zero-latency test-bench dmem and is the memory end of the core's dmem interface.

---
 rtl/dmem_responder_pkg.sv | 30 +++
 rtl/dmem_lane_align.sv | 54 +++++
 rtl/dmem_responder.sv | 158 +++++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared definitions for the data-memory responder: access-size encodings,
//   RISC-V mcause codes for load/store faults, and FSM state encodings.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_ACCESS      = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_STORE_ACCESS     = 4'd7;

  // Misalignment outranks an access fault when both apply.
  function automatic logic [3:0] fault_cause(input logic write, input logic misaligned);
    if (write) return misaligned ? CAUSE_STORE_MISALIGNED : CAUSE_STORE_ACCESS;
    else       return misaligned ? CAUSE_LOAD_MISALIGNED  : CAUSE_LOAD_ACCESS;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align
//   Combinational byte-lane steering for one access.
//   off        : byte offset within the word (addr[1:0])
//   size       : access size
//   wdata      : right-aligned store data
//   rword      : full word read from the array
//   be         : byte enables for the store
//   lane_wdata : store data replicated onto every lane
//   rdata      : load data shifted down and zero-extended
//   misaligned : half on an odd address or word not on a 4-byte boundary
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    be         = 4'b0000;
    lane_wdata = wdata;
    misaligned = 1'b0;
    shifted    = rword >> {off, 3'b000};
    rdata      = shifted;
    case (size)
      SIZE_BYTE: begin
        be         = 4'b0001 << off;
        lane_wdata = {4{wdata[7:0]}};
        rdata      = {24'h0, shifted[7:0]};
      end
      SIZE_HALF: begin
        be         = 4'b0011 << off;
        lane_wdata = {2{wdata[15:0]}};
        rdata      = {16'h0, shifted[15:0]};
        misaligned = off[0];
      end
      SIZE_WORD: begin
        be         = 4'b1111;
        misaligned = (off != 2'b00);
      end
      default: be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory end of the core's dmem interface. Serves one load or store at a
//   time with LATENCY wait states, checks alignment and address range, and
//   reports faults as RISC-V mcause codes.
//   clk, reset_x          : clock, asynchronous active-low reset
//   i_req .. i_wdata      : request, held by the initiator through o_done
//   o_busy                : a request is in flight (state != IDLE)
//   o_done                : one-cycle completion pulse
//   o_rdata               : right-aligned zero-extended load data, held
//   o_fault, o_cause      : fault flag and mcause, valid with o_done
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0002_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        i_req,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  output logic [3:0]  o_cause
);

  localparam int DEPTH = 1 << ADDR_W;

  state_e      state;
  logic [2:0]  cnt;
  logic        write_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH];

  // In IDLE the live request is checked (and, with zero latency, performed);
  // afterwards only the captured copy is used.
  logic        idle;
  logic        sel_write;
  logic [31:0] sel_addr;
  logic [1:0]  sel_size;
  logic [31:0] sel_wdata;
  logic [31:0] off_addr;
  logic        in_range;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0] rword;
  logic [3:0]  be;
  logic [31:0] lane_wdata;
  logic [31:0] rdata_al;
  logic        misaligned;
  logic        fault;
  logic        access;

  assign idle      = (state == ST_IDLE);
  assign sel_write = idle ? i_write : write_q;
  assign sel_addr  = idle ? i_addr  : addr_q;
  assign sel_size  = idle ? i_size  : size_q;
  assign sel_wdata = idle ? i_wdata : wdata_q;

  // Unsigned wrap makes addresses below the base look huge, so one compare
  // covers both ends of the window.
  assign off_addr = sel_addr - BASE_ADDR;
  assign in_range = ((off_addr >> (ADDR_W + 2)) == 32'd0);
  assign word_idx = off_addr[ADDR_W+1:2];
  assign rword    = mem[word_idx];

  dmem_lane_align u_align (
    .off        (off_addr[1:0]),
    .size       (size_e'(sel_size)),
    .wdata      (sel_wdata),
    .rword      (rword),
    .be         (be),
    .lane_wdata (lane_wdata),
    .rdata      (rdata_al),
    .misaligned (misaligned)
  );

  assign fault  = misaligned || (sel_size == SIZE_RSVD) || !in_range;
  assign access = (idle && i_req && !fault && (LATENCY == 0)) ||
                  ((state == ST_WAIT) && (cnt == 3'd1));

  // NOTE: the array has no reset; clearing thousands of words is not wanted.
  // An asynchronous reset forces IDLE before any later edge, so access is
  // already low and no partial store can land.
  always_ff @(posedge clk) begin
    if (access && sel_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state   <= ST_IDLE;
      cnt     <= 3'd0;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      size_q  <= 2'b00;
      wdata_q <= 32'h0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_rdata <= 32'h0;
      o_fault <= 1'b0;
      o_cause <= 4'd0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_req) begin
            write_q <= i_write;
            addr_q  <= i_addr;
            size_q  <= i_size;
            wdata_q <= i_wdata;
            o_busy  <= 1'b1;
            if (fault) begin
              o_fault <= 1'b1;
              o_cause <= fault_cause(i_write, misaligned);
              o_done  <= 1'b1;
              state   <= ST_DONE;
            end else if (LATENCY == 0) begin
              if (!i_write) o_rdata <= rdata_al;
              o_done <= 1'b1;
              state  <= ST_DONE;
            end else begin
              cnt   <= 3'(LATENCY);
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 3'd1) begin
            if (!write_q) o_rdata <= rdata_al;
            o_done <= 1'b1;
            state  <= ST_DONE;
          end
          cnt <= cnt - 3'd1;
        end
        ST_DONE: begin
          o_busy  <= 1'b0;
          o_fault <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Directed bench for dmem_responder. A byte-addressed reference memory and
//   a per-request timing model give the expected outputs; one process compares
//   the DUT against them every cycle, and literal checks pin key results.
module tb_dmem_responder;

  localparam int          LAT  = 2;
  localparam int          AW   = 12;
  localparam logic [31:0] BASE = 32'h0002_0000;

  logic        clk = 1'b0;
  logic        reset_x;
  logic        i_req = 1'b0;
  logic        i_write = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic [1:0]  i_size = 2'b00;
  logic [31:0] i_wdata = 32'h0;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_fault;
  logic [3:0]  o_cause;

  dmem_responder #(.ADDR_W(AW), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_x (reset_x),
    .i_req   (i_req),
    .i_write (i_write),
    .i_addr  (i_addr),
    .i_size  (i_size),
    .i_wdata (i_wdata),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_rdata (o_rdata),
    .o_fault (o_fault),
    .o_cause (o_cause)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte-addressed memory plus the in-flight request.
  bit [7:0]    mem_b [int unsigned];
  bit          txn = 1'b0;
  int          t0 = 0;
  int          t_len = 0;
  bit          exp_fault_t;
  logic [3:0]  exp_cause_t;
  logic [31:0] exp_load_t;
  bit          load_ok_t;
  logic [31:0] exp_rd = 32'h0;

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic void model(input bit w, input logic [31:0] a, input logic [1:0] sz,
                                output bit f, output logic [3:0] c, output logic [31:0] rd);
    bit mis;
    bit acc;
    mis = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    acc = (sz == 2'b11) || ((a - BASE) >= 32'(4 * (1 << AW)));
    f   = mis || acc;
    if (w) c = mis ? 4'd6 : 4'd7;
    else   c = mis ? 4'd4 : 4'd5;
    rd = 32'h0;
    if (!f && !w) begin
      for (int i = 0; i < size_bytes(sz); i++)
        rd = rd | (32'(mem_b[a + 32'(i)]) << (8 * i));
    end
  endfunction

  function automatic void commit(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    for (int i = 0; i < size_bytes(sz); i++)
      mem_b[a + 32'(i)] = wd[8*i +: 8];
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    int rel;
    if (txn) begin
      rel = cyc - t0;
      check("busy", 32'(o_busy), 32'(rel >= 1 && rel <= t_len));
      check("done", 32'(o_done), 32'(rel == t_len));
      if (rel == t_len) begin
        check("fault", 32'(o_fault), 32'(exp_fault_t));
        if (exp_fault_t) check("cause", 32'(o_cause), 32'(exp_cause_t));
        check("rdata", o_rdata, load_ok_t ? exp_load_t : exp_rd);
      end else begin
        check("rdata", o_rdata, exp_rd);
      end
    end else begin
      check("idle_busy", 32'(o_busy), 32'd0);
      check("idle_done", 32'(o_done), 32'd0);
      check("idle_rdata", o_rdata, exp_rd);
    end
  end

  // Present a request in c0 and hold it through the expected done cycle.
  task automatic start_req(input bit w, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] wd);
    bit          f;
    logic [3:0]  c;
    logic [31:0] rd;
    model(w, a, sz, f, c, rd);
    @(negedge clk); #1;
    i_req = 1'b1; i_write = w; i_addr = a; i_size = sz; i_wdata = wd;
    exp_fault_t = f; exp_cause_t = c; exp_load_t = rd;
    load_ok_t = !w && !f;
    t_len = f ? 1 : LAT + 1;
    t0 = cyc;
    txn = 1'b1;
  endtask

  // Returns just after the compare in the done cycle; outputs still valid.
  task automatic req(input bit w, input logic [31:0] a, input logic [1:0] sz,
                     input logic [31:0] wd);
    start_req(w, a, sz, wd);
    repeat (t_len) @(negedge clk);
    #1;
    i_req = 1'b0;
    txn = 1'b0;
    if (load_ok_t) exp_rd = exp_load_t;
    if (w && !exp_fault_t) commit(a, sz, wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_x = 1'b1;
    #2 reset_x = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy",  32'(o_busy),  32'd0);
    check("rst_done",  32'(o_done),  32'd0);
    check("rst_fault", 32'(o_fault), 32'd0);
    check("rst_cause", 32'(o_cause), 32'd0);
    check("rst_rdata", o_rdata, 32'h0);
    reset_x = 1'b1;

    // 1: word store, done in c3
    req(1'b1, 32'h0002_0000, 2'b10, 32'hDEAD_BEEF);
    check("t1_done",  32'(o_done),  32'd1);
    check("t1_fault", 32'(o_fault), 32'd0);

    // 2: byte merge
    req(1'b1, 32'h0002_0001, 2'b00, 32'hFFFF_FF55);
    req(1'b0, 32'h0002_0000, 2'b10, 32'h0);
    check("t2_word", o_rdata, 32'hDEAD_55EF);

    // 3: sub-word loads
    req(1'b0, 32'h0002_0002, 2'b01, 32'h0);
    check("t3_half", o_rdata, 32'h0000_DEAD);
    req(1'b0, 32'h0002_0003, 2'b00, 32'h0);
    check("t3_byte", o_rdata, 32'h0000_00DE);

    // 4: misaligned
    req(1'b0, 32'h0002_0001, 2'b01, 32'h0);
    check("t4_ld_cause", 32'(o_cause), 32'd4);
    check("t4_ld_rdata", o_rdata, 32'h0000_00DE);
    req(1'b1, 32'h0002_0002, 2'b10, 32'h0BAD_0BAD);
    check("t4_st_cause", 32'(o_cause), 32'd6);
    req(1'b0, 32'h0002_0000, 2'b10, 32'h0);
    check("t4_unchanged", o_rdata, 32'hDEAD_55EF);

    // 5: access faults
    req(1'b0, 32'h0002_4000, 2'b10, 32'h0);
    check("t5_above", 32'(o_cause), 32'd5);
    req(1'b1, 32'h0001_FFFC, 2'b10, 32'h1111_1111);
    check("t5_below", 32'(o_cause), 32'd7);
    req(1'b0, 32'h0002_0000, 2'b11, 32'h0);
    check("t5_rsvd_ld", 32'(o_cause), 32'd5);
    req(1'b1, 32'h0002_0000, 2'b11, 32'h0);

    // Top of the window and lane replication
    req(1'b1, 32'h0002_3FFC, 2'b10, 32'h1122_3344);
    req(1'b1, 32'h0002_3FFE, 2'b01, 32'hA5A5_1234);
    req(1'b0, 32'h0002_3FFC, 2'b10, 32'h0);
    check("top_word", o_rdata, 32'h1234_3344);
    req(1'b1, 32'h0002_0010, 2'b10, 32'hCAFE_F00D);
    req(1'b1, 32'h0002_0012, 2'b00, 32'hFFFF_FF77);
    req(1'b0, 32'h0002_0012, 2'b01, 32'h0);
    check("mix_half", o_rdata, 32'h0000_CA77);
    req(1'b0, 32'h0002_0010, 2'b00, 32'h0);
    check("mix_byte", o_rdata, 32'h0000_000D);

    // 6: reset during WAIT drops the store
    start_req(1'b1, 32'h0002_0000, 2'b10, 32'h1234_5678);
    @(negedge clk); #1;
    reset_x = 1'b0;
    i_req = 1'b0;
    txn = 1'b0;
    exp_rd = 32'h0;
    @(negedge clk); #1;
    check("t6_busy",  32'(o_busy),  32'd0);
    check("t6_done",  32'(o_done),  32'd0);
    check("t6_fault", 32'(o_fault), 32'd0);
    check("t6_cause", 32'(o_cause), 32'd0);
    check("t6_rdata", o_rdata, 32'h0);
    reset_x = 1'b1;
    req(1'b0, 32'h0002_0000, 2'b10, 32'h0);
    check("t6_old", o_rdata, 32'hDEAD_55EF);

    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
